// File: rtl/avalon_test_ram.sv
// 64 x 32-bit Avalon-MM slave RAM for CPU benches, with a level-sensitive backdoor preload port.
// Define RAM_WAITSTATE_EN to add one wait state per bus transfer (waitrequest/ack handshake).
module avalon_test_ram (
    input  logic        clk,
    input  logic        RAM_Reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    output logic        waitrequest,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    input  logic        inst_input,
    input  logic [7:0]  inst_addr,
    input  logic [31:0] instruction
);

    // Each word lives in two places: a clocked copy for bus writes and a transparent
    // copy for backdoor writes. The per-word sel bits record which copy is newer:
    // the word reads from the backdoor copy whenever r_ff_sel and r_bd_sel differ.
    logic [31:0] r_ff [64];
    logic [31:0] r_bd [64];
    logic [63:0] r_ff_sel;
    logic [63:0] r_bd_sel;

    logic [7:0]  w_bd_loc;
    logic [5:0]  w_bd_idx;
    logic [5:0]  w_bus_idx;
    logic        w_bd_en;
    logic        w_bd_hits_bus;
    logic        w_commit;
    logic [63:0] w_bd_newer;
    logic [31:0] w_cur;
    logic [31:0] w_merged;

    assign w_bd_loc      = inst_addr - 8'd4;
    assign w_bd_idx      = w_bd_loc[7:2];
    assign w_bus_idx     = address[7:2];
    assign w_bd_en       = inst_input & ~RAM_Reset;
    assign w_bd_hits_bus = w_bd_en && (w_bd_idx == w_bus_idx);
    assign w_bd_newer    = r_ff_sel ^ r_bd_sel;

    assign w_cur    = w_bd_newer[w_bus_idx] ? r_bd[w_bus_idx] : r_ff[w_bus_idx];
    assign readdata = w_cur;

    always_comb begin
        w_merged = w_cur;
        for (int n = 0; n < 4; n++) begin
            if (byteenable[n]) begin
                w_merged[8*n +: 8] = writedata[8*n +: 8];
            end
        end
    end

`ifdef RAM_WAITSTATE_EN
    logic r_ack;
    logic w_unused;

    always_ff @(posedge clk) begin
        if (RAM_Reset) begin
            r_ack <= 1'b0;
        end else if (r_ack) begin
            r_ack <= 1'b0;
        end else if (read | write) begin
            r_ack <= 1'b1;
        end
    end

    assign waitrequest = (read | write) & ~r_ack;
    assign w_commit    = write & r_ack;
    assign w_unused    = &{1'b0, address[31:8], address[1:0], w_bd_loc[1:0]};
`else
    logic w_unused;

    assign waitrequest = 1'b0;
    assign w_commit    = write;
    assign w_unused    = &{1'b0, read, address[31:8], address[1:0], w_bd_loc[1:0]};
`endif

    // A backdoor write to the same word at this edge takes precedence over the bus write.
    always_ff @(posedge clk) begin
        if (RAM_Reset) begin
            for (int i = 0; i < 64; i++) begin
                r_ff[i] <= 32'd0;
            end
            r_ff_sel <= 64'd0;
        end else if (w_commit && !w_bd_hits_bus) begin
            r_ff[w_bus_idx]     <= w_merged;
            r_ff_sel[w_bus_idx] <= r_bd_sel[w_bus_idx];
        end
    end

    // Transparent backdoor store: tracks instruction/inst_addr with no clock involved.
    always_latch begin
        for (int i = 0; i < 64; i++) begin
            if (RAM_Reset) begin
                r_bd_sel[i] <= 1'b0;
            end else if (inst_input && (w_bd_idx == 6'(i))) begin
                r_bd[i]     <= instruction;
                r_bd_sel[i] <= ~r_ff_sel[i];
            end
        end
    end

endmodule

// File: tb/tb_avalon_test_ram.sv
// Randomized self-checking bench for avalon_test_ram against a word-array reference model.
module tb_avalon_test_ram;

    logic        clk = 1'b0;
    logic        RAM_Reset;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        inst_input;
    logic [7:0]  inst_addr;
    logic [31:0] instruction;

    logic [31:0] model [64];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    avalon_test_ram dut (
        .clk         (clk),
        .RAM_Reset   (RAM_Reset),
        .address     (address),
        .read        (read),
        .write       (write),
        .waitrequest (waitrequest),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .readdata    (readdata),
        .inst_input  (inst_input),
        .inst_addr   (inst_addr),
        .instruction (instruction)
    );

    function automatic int bus_word(input logic [31:0] a);
        return int'(a % 32'd256) / 4;
    endfunction

    function automatic int bd_word(input logic [7:0] loc);
        return ((int'(loc) + 252) % 256) / 4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        #1;
        while (waitrequest) begin
            if (n == 4) begin
                chk(tag, {31'd0, waitrequest}, 32'd0);
                break;
            end
            @(negedge clk);
            #1;
            n++;
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        int w;
        @(negedge clk);
        address = a; writedata = d; byteenable = be; write = 1'b1;
        wait_ready("wr_stall");
        @(posedge clk);
        #1;
        write = 1'b0;
        w = bus_word(a);
        for (int k = 0; k < 4; k++) begin
            if (be[k]) model[w][8*k +: 8] = d[8*k +: 8];
        end
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a; read = 1'b1; byteenable = 4'($urandom_range(0, 15));
        wait_ready("rd_stall");
        d = readdata;
        @(posedge clk);
        #1;
        read = 1'b0;
    endtask

    task automatic bd_put(input logic [7:0] loc, input logic [31:0] d);
        inst_input = 1'b1; inst_addr = loc; instruction = d;
        #1;
        model[bd_word(loc)] = d;
    endtask

    task automatic bd_done();
        inst_input = 1'b0;
        #1;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        chk(tag, d, exp);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] a;
        int op;

        RAM_Reset = 1'b1; address = '0; read = 1'b0; write = 1'b0;
        writedata = '0; byteenable = '0; inst_input = 1'b0; inst_addr = '0; instruction = '0;
        for (int i = 0; i < 64; i++) model[i] = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_wait", {31'd0, waitrequest}, 32'd0);
        chk("reset_rdata", readdata, 32'd0);
        @(negedge clk);
        RAM_Reset = 1'b0;

        // Reset clears previously loaded contents
        bd_put(8'h04, 32'hDEADBEEF);
        bd_put(8'h00, 32'h12345678);
        bd_done();
        read_check("pre_reset", 32'hBFC00000, 32'hDEADBEEF);
        @(negedge clk);
        RAM_Reset = 1'b1;
        @(posedge clk);
        #1;
        RAM_Reset = 1'b0;
        for (int i = 0; i < 64; i++) model[i] = 32'd0;
        read_check("rst_vec", 32'hBFC00000, 32'h00000000);
        read_check("rst_fc", 32'hBFC000FC, 32'h00000000);
        chk("rst_wait_idle", {31'd0, waitrequest}, 32'd0);

        // Backdoor mapping and bus aliasing
        bd_put(8'h04, 32'h240ABFC0);
        bd_put(8'h1C, 32'h00000040);
        bd_done();
        read_check("bd_vec", 32'hBFC00000, 32'h240ABFC0);
        read_check("bd_18_hi", 32'hBFC00018, 32'h00000040);
        read_check("bd_18_lo", 32'h00000018, 32'h00000040);
        bd_put(8'h00, 32'hCAFEF00D);
        bd_done();
        read_check("bd_alias_fc", 32'hBFC000FC, 32'hCAFEF00D);

        // Byte-enable write on lanes 0 and 2
        bd_put(8'h24, 32'h11223344);
        bd_done();
        bus_write(32'hBFC00020, 32'hAABBCCDD, 4'b0101);
        read_check("be_0101", 32'hBFC00020, 32'h11BB33DD);

        // Dropping inst_input freezes the word
        bd_put(8'h30, 32'h55AA55AA);
        bd_done();
        instruction = 32'hFFFFFFFF; inst_addr = 8'h30;
        #1;
        read_check("bd_freeze", 32'h0000002C, 32'h55AA55AA);

        // Read and write together: pre-write word visible, write still lands
        @(negedge clk);
        address = 32'h0000002C; read = 1'b1; write = 1'b1;
        writedata = 32'h01020304; byteenable = 4'hF;
        #1;
        chk("rw_prewrite", readdata, 32'h55AA55AA);
        wait_ready("rw_stall");
        @(posedge clk);
        #1;
        read = 1'b0; write = 1'b0;
        model[bus_word(32'h2C)] = 32'h01020304;
        read_check("rw_postwrite", 32'h0000002C, 32'h01020304);

        // Backdoor wins a same-word collision; other words still serviced
        inst_input = 1'b1; inst_addr = 8'h44; instruction = 32'h0BADC0DE;
        #1;
        bus_write(32'h00000040, 32'hFFFFFFFF, 4'hF);
        model[bd_word(8'h44)] = 32'h0BADC0DE;
        bus_write(32'h00000050, 32'h13579BDF, 4'hF);
        bd_done();
        read_check("bd_wins", 32'h00000040, 32'h0BADC0DE);
        read_check("bus_during_bd", 32'h00000050, 32'h13579BDF);

`ifdef RAM_WAITSTATE_EN
        // Held read: alternating stall / data cycles
        @(negedge clk);
        address = 32'hBFC00000; read = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("ws_wait_seq", {31'd0, waitrequest}, (k % 2 == 0) ? 32'd1 : 32'd0);
            if (k % 2 == 1) chk("ws_data", readdata, model[0]);
            @(negedge clk);
        end
        read = 1'b0;
        // Write withdrawn while stalled does not commit
        address = 32'h00000040; writedata = 32'hDEAD0000; byteenable = 4'hF; write = 1'b1;
        #1;
        chk("ws_abort_stall", {31'd0, waitrequest}, 32'd1);
        @(posedge clk);
        #1;
        write = 1'b0;
        @(posedge clk);
        #1;
        chk("ws_abort_idle", {31'd0, waitrequest}, 32'd0);
        read_check("ws_abort_mem", 32'h00000040, model[16]);
`endif

        // Randomized traffic against the model
        for (int it = 0; it < 300; it++) begin
            op = $urandom_range(0, 3);
            a  = $urandom;
            if (op == 0) begin
                bus_write(a, $urandom, 4'($urandom_range(0, 15)));
            end else if (op == 3) begin
                for (int e = 0; e < $urandom_range(1, 3); e++) begin
                    bd_put(8'($urandom_range(0, 255)), $urandom);
                end
                bd_done();
            end else begin
                bus_read(a, d);
                chk("rand_read", d, model[bus_word(a)]);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
